// File: rtl/fb_pkg.sv
// Shared constants and types for the filter-bank sample scheduler.
package fb_pkg;

   localparam int NBANDS        = 16;
   localparam int IN_W          = 13;
   localparam int OUT_W         = 33;
   localparam int PRIME_SAMPLES = 119;
   localparam int CNT_W         = $clog2(PRIME_SAMPLES + 1);
   localparam int BAND_W        = 4;

   typedef logic [BAND_W-1:0] band_idx_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FIRE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DRAIN
   } fb_sched_state_t;

endpackage

// File: rtl/fb_next_band.sv
// Priority encoder: lowest set mask bit strictly above the current index.
// cur_i is signed so that -1 searches from band 0.
module fb_next_band
   import fb_pkg::*;
(
   input  logic [NBANDS-1:0] mask_i,
   input  logic [BAND_W:0]   cur_i,
   output band_idx_t         nxt_o,
   output logic              none_o
);

   always_comb begin
      // NOTE: defaults first so no path leaves an output unassigned, which would infer a latch.
      nxt_o  = '0;
      none_o = 1'b1;
      for (int k = NBANDS - 1; k >= 0; k--) begin
         if (mask_i[k] && (k > int'($signed(cur_i)))) begin
            nxt_o  = band_idx_t'(k);
            none_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/fb_sample_scheduler.sv
// Feeds one sample at a time into the 16-band FIR bank, waits for it to settle,
// snapshots all bands and serialises the enabled ones onto one output stream.
module fb_sample_scheduler
   import fb_pkg::*;
#(
   parameter int FB_LATENCY      = 2,
   parameter bit SUPPRESS_WARMUP = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_W-1:0]         in_data,
   output logic                    fb_clk_enable,
   output logic [IN_W-1:0]         fb_filter_in,
   input  logic [NBANDS*OUT_W-1:0] fb_out_flat,
   input  logic [NBANDS-1:0]       band_mask,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_data,
   output logic [3:0]              out_band,
   output logic                    out_last,
   output logic                    primed
);

   localparam logic [CNT_W-1:0] PRIME_CNT   = CNT_W'(PRIME_SAMPLES);
   localparam logic [3:0]       SETTLE_LOAD = 4'(FB_LATENCY - 1);

   fb_sched_state_t   state_q, state_d;
   logic [3:0]        settle_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              warmup_q;
   logic              primed_q;
   logic              recover_q;
   logic [IN_W-1:0]   filt_q;
   logic [OUT_W-1:0]  snap_q [NBANDS];
   logic [NBANDS-1:0] mask_q;
   band_idx_t         idx_q;

   band_idx_t first_idx, next_idx;
   logic      first_none, next_none;
   logic      accept, skip;

   fb_next_band u_first (
      .mask_i (band_mask),
      .cur_i  ({(BAND_W + 1){1'b1}}),
      .nxt_o  (first_idx),
      .none_o (first_none)
   );

   fb_next_band u_next (
      .mask_i (mask_q),
      .cur_i  ({1'b0, idx_q}),
      .nxt_o  (next_idx),
      .none_o (next_none)
   );

   assign accept = in_valid && in_ready;
   assign skip   = first_none || (SUPPRESS_WARMUP && warmup_q);

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (accept) state_d = ST_FIRE;
         ST_FIRE:    state_d = ST_SETTLE;
         ST_SETTLE:  if (settle_q == 4'd0) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = skip ? ST_IDLE : ST_DRAIN;
         ST_DRAIN:   if (out_ready && next_none) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // A skipped sample spends one recovery cycle in IDLE so every sample period is at least 4+FB_LATENCY.
   always_comb begin
      in_ready      = 1'b0;
      fb_clk_enable = 1'b0;
      out_valid     = 1'b0;
      out_last      = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_IDLE:  in_ready = !recover_q;
            ST_FIRE:  fb_clk_enable = 1'b1;
            ST_DRAIN: begin
               out_valid = 1'b1;
               out_last  = next_none;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         filt_q    <= '0;
         cnt_q     <= '0;
         warmup_q  <= 1'b0;
         primed_q  <= 1'b0;
         recover_q <= 1'b0;
         settle_q  <= '0;
         mask_q    <= '0;
         idx_q     <= '0;
         // NOTE: the snapshot is cleared on reset because out_data reads it directly and must be 0.
         for (int k = 0; k < NBANDS; k++) snap_q[k] <= '0;
      end else begin
         recover_q <= (state_q == ST_CAPTURE) && skip;
         if (accept) filt_q <= in_data;

         if (state_q == ST_FIRE) begin
            warmup_q <= (cnt_q < PRIME_CNT);
            if (cnt_q != PRIME_CNT) cnt_q <= cnt_q + 1'b1;
            settle_q <= SETTLE_LOAD;
         end else if (state_q == ST_SETTLE && settle_q != 4'd0) begin
            settle_q <= settle_q - 1'b1;
         end

         if (cnt_q == PRIME_CNT) primed_q <= 1'b1;

         if (state_q == ST_CAPTURE) begin
            for (int k = 0; k < NBANDS; k++) snap_q[k] <= fb_out_flat[k*OUT_W +: OUT_W];
            mask_q <= band_mask;
            idx_q  <= first_idx;
         end else if (state_q == ST_DRAIN && out_ready && !next_none) begin
            idx_q <= next_idx;
         end
      end
   end

   assign fb_filter_in = filt_q;
   assign out_data     = snap_q[idx_q];
   assign out_band     = idx_q;
   assign primed       = primed_q;

endmodule

// File: tb/tb_fb_sample_scheduler.sv
// Scoreboard bench for fb_sample_scheduler: two instances (warm-up emitted / suppressed)
// share a behavioural filter-bank model whose outputs appear FB_LATENCY cycles after each strobe.
module tb_fb_sample_scheduler;
   import fb_pkg::*;

   localparam int L = 2;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic [3:0]       band;
      logic             last;
   } word_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [IN_W-1:0]         in_data;
   logic [NBANDS*OUT_W-1:0] fb_out_flat;
   logic [NBANDS-1:0]       band_mask;
   logic                    out_ready;

   logic in_valid_a, in_ready_a, fb_en_a, out_valid_a, out_last_a, primed_a;
   logic [IN_W-1:0] filt_a;
   logic [OUT_W-1:0] out_data_a;
   logic [3:0] out_band_a;

   logic in_valid_b, in_ready_b, fb_en_b, out_valid_b, out_last_b, primed_b;
   logic [IN_W-1:0] filt_b;
   logic [OUT_W-1:0] out_data_b;
   logic [3:0] out_band_b;

   fb_sample_scheduler #(.FB_LATENCY(L), .SUPPRESS_WARMUP(1'b0)) dut_a (
      .clock(clock), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_data(in_data), .fb_clk_enable(fb_en_a), .fb_filter_in(filt_a),
      .fb_out_flat(fb_out_flat), .band_mask(band_mask), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_data(out_data_a), .out_band(out_band_a),
      .out_last(out_last_a), .primed(primed_a)
   );

   fb_sample_scheduler #(.FB_LATENCY(L), .SUPPRESS_WARMUP(1'b1)) dut_b (
      .clock(clock), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_data(in_data), .fb_clk_enable(fb_en_b), .fb_filter_in(filt_b),
      .fb_out_flat(fb_out_flat), .band_mask(band_mask), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_data(out_data_b), .out_band(out_band_b),
      .out_last(out_last_b), .primed(primed_b)
   );

   function automatic logic [OUT_W-1:0] band_val(input int k, input logic [IN_W-1:0] s);
      logic [OUT_W-1:0] v;
      v = OUT_W'($signed(s));
      v = v * OUT_W'(k + 1);
      v = v + (OUT_W'(k) << 24);
      return v;
   endfunction

   function automatic logic [IN_W-1:0] samp(input int n);
      return IN_W'(n * 613 + 7);
   endfunction

   // Bank model: sample latched on a strobe, visible on the outputs L cycles later.
   logic [IN_W-1:0] bank_pipe [L];
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < L; i++) bank_pipe[i] <= '0;
      end else begin
         if (fb_en_a || fb_en_b) bank_pipe[0] <= fb_en_a ? filt_a : filt_b;
         for (int i = 1; i < L; i++) bank_pipe[i] <= bank_pipe[i-1];
      end
   end

   always_comb begin
      fb_out_flat = '0;
      for (int k = 0; k < NBANDS; k++) fb_out_flat[k*OUT_W +: OUT_W] = band_val(k, bank_pipe[L-1]);
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int words_b = 0;
   int en_cnt_b = 0;
   word_t exp_a[$];
   word_t exp_b[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_exp(input bit to_b, input logic [IN_W-1:0] s, input logic [NBANDS-1:0] m);
      word_t w;
      for (int k = 0; k < NBANDS; k++) begin
         if (m[k]) begin
            w.data = band_val(k, s);
            w.band = 4'(k);
            w.last = ((m >> (k + 1)) == '0);
            if (to_b) exp_b.push_back(w);
            else      exp_a.push_back(w);
         end
      end
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial forever begin
      @(negedge clock);
      if (!reset && fb_en_b) en_cnt_b++;
   end

   initial begin : mon_a
      word_t w;
      forever begin
         @(negedge clock);
         if (!reset && out_valid_a && out_ready) begin
            check("a_word_expected", 64'(exp_a.size() != 0), 64'd1);
            if (exp_a.size() != 0) begin
               w = exp_a.pop_front();
               check("a_data", 64'(out_data_a), 64'(w.data));
               check("a_band", 64'(out_band_a), 64'(w.band));
               check("a_last", 64'(out_last_a), 64'(w.last));
            end
         end
      end
   end

   initial begin : mon_b
      word_t w;
      forever begin
         @(negedge clock);
         if (!reset && out_valid_b && out_ready) begin
            words_b++;
            check("b_word_expected", 64'(exp_b.size() != 0), 64'd1);
            if (exp_b.size() != 0) begin
               w = exp_b.pop_front();
               check("b_data", 64'(out_data_b), 64'(w.data));
               check("b_band", 64'(out_band_b), 64'(w.band));
               check("b_last", 64'(out_last_b), 64'(w.last));
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Presents s to dut_b, returns in cycle T+1 with t_acc = cycle number of the accept.
   task automatic send_b(input logic [IN_W-1:0] s, input bit keep, output int t_acc);
      int n;
      in_data = s;
      in_valid_b = 1'b1;
      n = 0;
      while (!in_ready_b && n < 50) begin
         step();
         n++;
      end
      check("b_ready_timeout", 64'(in_ready_b), 64'd1);
      t_acc = cyc;
      step();
      if (!keep) in_valid_b = 1'b0;
   endtask

   task automatic wait_drain_b();
      int n;
      n = 0;
      while (exp_b.size() != 0 && n < 100) begin
         step();
         n++;
      end
      check("b_drain_done", 64'(exp_b.size()), 64'd0);
      step();
   endtask

   task automatic wait_valid_b();
      int n;
      n = 0;
      while (!out_valid_b && n < 50) begin
         step();
         n++;
      end
      check("b_valid_timeout", 64'(out_valid_b), 64'd1);
   endtask

   task automatic prime_b(input int count, input int base);
      int t;
      for (int n = 1; n <= count; n++) begin
         send_b(samp(base + n), 1'b1, t);
         if (n == count) begin
            check("primed_at_fire", 64'(primed_b), 64'd0);
            step();
            check("primed_at_fire_p1", 64'(primed_b), 64'd0);
            step();
            check("primed_at_fire_p2", 64'(primed_b), 64'd1);
         end else if (n == count - 1) begin
            check("primed_before_last", 64'(primed_b), 64'd0);
         end
      end
      in_valid_b = 1'b0;
   endtask

   initial begin
      int t1, t2, e0, w0;
      logic [IN_W-1:0] s;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      in_data    = '0;
      band_mask  = '0;
      out_ready  = 1'b1;
      reset      = 1'b1;

      // Reset state
      repeat (3) step();
      check("rst_in_ready_a", 64'(in_ready_a), 64'd0);
      check("rst_fb_en_a", 64'(fb_en_a), 64'd0);
      check("rst_out_valid_b", 64'(out_valid_b), 64'd0);
      check("rst_out_last_a", 64'(out_last_a), 64'd0);
      check("rst_primed_b", 64'(primed_b), 64'd0);
      check("rst_filt_a", 64'(filt_a), 64'd0);
      check("rst_out_data_b", 64'(out_data_b), 64'd0);
      check("rst_out_band_b", 64'(out_band_b), 64'd0);
      reset = 1'b0;
      step();
      check("idle_in_ready_a", 64'(in_ready_a), 64'd1);

      // Single sample, warm-up emitted, mask 0005: cycle-exact timing
      s = 13'h0ABC;
      band_mask = 16'h0005;
      push_exp(1'b0, s, 16'h0005);
      in_data = s;
      in_valid_a = 1'b1;
      step();                                    // T+1
      in_valid_a = 1'b0;
      check("t1_fb_en", 64'(fb_en_a), 64'd1);
      check("t1_in_ready", 64'(in_ready_a), 64'd0);
      check("t1_filter_in", 64'(filt_a), 64'(s));
      step();                                    // T+2
      check("t2_fb_en", 64'(fb_en_a), 64'd0);
      step(); step();                            // T+4
      check("t4_out_valid", 64'(out_valid_a), 64'd0);
      step();                                    // T+5
      check("t5_out_valid", 64'(out_valid_a), 64'd1);
      check("t5_out_band", 64'(out_band_a), 64'd0);
      step();                                    // T+6
      check("t6_out_band", 64'(out_band_a), 64'd2);
      check("t6_out_last", 64'(out_last_a), 64'd1);
      step();                                    // T+7
      check("t7_in_ready", 64'(in_ready_a), 64'd1);
      check("t7_out_valid", 64'(out_valid_a), 64'd0);
      check("a_queue_empty", 64'(exp_a.size()), 64'd0);

      // Warm-up with suppression: 119 silent samples, then sample 120 emits all 16 bands
      band_mask = 16'hFFFF;
      prime_b(PRIME_SAMPLES, 0);
      check("warmup_no_words", 64'(words_b), 64'd0);
      push_exp(1'b1, samp(120), 16'hFFFF);
      send_b(samp(120), 1'b0, t1);
      wait_drain_b();
      check("s120_word_count", 64'(words_b), 64'd16);

      // Backpressure held on band 3
      s = samp(121);
      push_exp(1'b1, s, 16'hFFFF);
      send_b(s, 1'b0, t1);
      for (int n = 0; n < 40 && !(out_valid_b && out_band_b == 4'd3); n++) step();
      out_ready = 1'b0;
      e0 = en_cnt_b;
      for (int n = 0; n < 5; n++) begin
         step();
         check("bp_out_data", 64'(out_data_b), 64'(band_val(3, s)));
         check("bp_out_band", 64'(out_band_b), 64'd3);
         check("bp_out_valid", 64'(out_valid_b), 64'd1);
         check("bp_in_ready", 64'(in_ready_b), 64'd0);
      end
      check("bp_no_extra_fire", 64'(en_cnt_b - e0), 64'd0);
      out_ready = 1'b1;
      wait_drain_b();

      // Mask 0 after primed: no output, period exactly 4+L
      band_mask = 16'h0000;
      w0 = words_b;
      send_b(samp(122), 1'b1, t1);
      send_b(samp(123), 1'b0, t2);
      check("mask0_period", 64'(t2 - t1), 64'(4 + L));
      repeat (8) step();
      check("mask0_no_words", 64'(words_b - w0), 64'd0);

      // Mask change during drain affects only the next sample
      band_mask = 16'h8001;
      push_exp(1'b1, samp(124), 16'h8001);
      send_b(samp(124), 1'b0, t1);
      wait_valid_b();
      band_mask = 16'h0002;
      push_exp(1'b1, samp(125), 16'h0002);
      send_b(samp(125), 1'b0, t1);
      wait_drain_b();

      // Reset mid-drain abandons the sample and clears priming
      band_mask = 16'hFFFF;
      out_ready = 1'b0;
      send_b(samp(126), 1'b0, t1);
      wait_valid_b();
      reset = 1'b1;
      step();
      check("mrst_out_valid", 64'(out_valid_b), 64'd0);
      check("mrst_primed", 64'(primed_b), 64'd0);
      check("mrst_in_ready", 64'(in_ready_b), 64'd0);
      check("mrst_out_data", 64'(out_data_b), 64'd0);
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      step();
      check("post_rst_in_ready", 64'(in_ready_b), 64'd1);
      w0 = words_b;
      prime_b(PRIME_SAMPLES, 200);
      repeat (8) step();
      check("reprime_no_words", 64'(words_b - w0), 64'd0);

      check("final_a_empty", 64'(exp_a.size()), 64'd0);
      check("final_b_empty", 64'(exp_b.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
